// File: rtl/ahb_decoder_if.sv
// Bus bundle between the AHB master/multiplexor side and the address decoder.
// Carries the address phase inputs, decode outputs, default-slave response and its debug state.
interface ahb_decoder_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int SLAVE_DEVICES = 4
);
  localparam int SEL_W = $clog2(SLAVE_DEVICES) + 1;

  // master_ready high at a rising edge accepts the current address phase (addr/trans)
  // and completes the previous data phase; while low, the master holds addr/trans stable.
  logic [ADDR_WIDTH-1:0]  addr;
  logic [1:0]             trans;
  logic                   master_ready;
  logic [SLAVE_DEVICES:0] selx;
  logic [SEL_W-1:0]       multip_sel;
  logic                   def_ready;
  logic                   def_resp;
  logic [ADDR_WIDTH-1:0]  err_addr;
  logic [7:0]             err_count;
  logic [1:0]             def_state;

  modport slave (
    input  addr, trans, master_ready,
    output selx, multip_sel, def_ready, def_resp, err_addr, err_count, def_state
  );

  modport master (
    output addr, trans, master_ready,
    input  selx, multip_sel, def_ready, def_resp, err_addr, err_count, def_state
  );
endinterface

// File: rtl/ahb_decoder.sv
// AHB address decoder: one-hot slave select, registered data-phase mux index,
// and a built-in default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_decoder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    SLAVE_DEVICES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int                    REGION_SHIFT  = 12
) (
  input  logic          clk,
  input  logic          rst,
  ahb_decoder_if.slave  bus
);
  localparam int SEL_W = $clog2(SLAVE_DEVICES) + 1;
  localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH + 1)'(SLAVE_DEVICES) << REGION_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]    off;
  logic [ADDR_WIDTH:0]    region;
  logic                   hit;
  logic [SLAVE_DEVICES:0] selx;
  logic [SEL_W-1:0]       sel_idx;
  logic                   err_start;

  // One extra bit keeps the window end from wrapping near the top of the address map.
  always_comb begin
    off    = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    region = off >> REGION_SHIFT;
    hit    = (bus.addr >= BASE_ADDR) && (off < WINDOW);
    selx   = '0;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (hit && (region == (ADDR_WIDTH + 1)'(i))) selx[i] = 1'b1;
    end
    if (!hit) selx[SLAVE_DEVICES] = 1'b1;
  end

  always_comb begin
    sel_idx = SEL_W'(SLAVE_DEVICES);
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (selx[i]) sel_idx = SEL_W'(i);
    end
  end

  assign bus.selx = selx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.multip_sel <= SEL_W'(SLAVE_DEVICES);
    end else if (bus.master_ready) begin
      bus.multip_sel <= sel_idx;
    end
  end

  // An accepted NONSEQ/SEQ to unmapped space starts an error sequence.
  assign err_start = bus.master_ready && selx[SLAVE_DEVICES] && bus.trans[1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (err_start) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = err_start ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.def_ready = 1'b1;
    bus.def_resp  = 1'b0;
    case (state_q)
      S_ERR1: begin
        bus.def_ready = 1'b0;
        bus.def_resp  = 1'b1;
      end
      S_ERR2: begin
        bus.def_ready = 1'b1;
        bus.def_resp  = 1'b1;
      end
      default: begin
        bus.def_ready = 1'b1;
        bus.def_resp  = 1'b0;
      end
    endcase
  end

  assign bus.def_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_addr  <= '0;
      bus.err_count <= '0;
    end else begin
      if ((state_q != S_ERR1) && err_start) bus.err_addr <= bus.addr;
      if ((state_q == S_ERR2) && (bus.err_count != 8'hFF)) bus.err_count <= bus.err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ahb_decoder.sv
// Directed testbench for ahb_decoder: decode boundaries, mux index timing,
// default-slave ERROR sequencing, error capture/saturation and reset priority.
module tb_ahb_decoder;
  localparam int AW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ahb_decoder_if #(.ADDR_WIDTH(AW), .SLAVE_DEVICES(N)) bus ();

  ahb_decoder #(
    .ADDR_WIDTH(AW), .SLAVE_DEVICES(N), .BASE_ADDR(32'h4000_0000), .REGION_SHIFT(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic mr);
    bus.addr         = a;
    bus.trans        = t;
    bus.master_ready = mr;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic rdy, input logic rsp, input logic [1:0] st);
    check({tag, "_ready"}, 64'(bus.def_ready), 64'(rdy));
    check({tag, "_resp"},  64'(bus.def_resp),  64'(rsp));
    check({tag, "_state"}, 64'(bus.def_state), 64'(st));
  endtask

  initial begin
    // Reset
    drive(32'h0, 2'b00, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    check("rst_msel",  64'(bus.multip_sel), 64'd4);
    check_resp("rst", 1'b1, 1'b0, 2'd0);
    check("rst_ecnt",  64'(bus.err_count), 64'd0);
    check("rst_eaddr", 64'(bus.err_addr), 64'd0);
    rst = 1'b0;

    // Mapped decode and region boundaries
    drive(32'h4000_1004, 2'b10, 1'b1);
    #1 check("selx_1004", 64'(bus.selx), 64'b00010);
    tick();
    check("msel_1", 64'(bus.multip_sel), 64'd1);
    check_resp("mapped", 1'b1, 1'b0, 2'd0);
    drive(32'h4000_3FFF, 2'b10, 1'b1);
    #1 check("selx_3fff", 64'(bus.selx), 64'b01000);
    tick();
    check("msel_3", 64'(bus.multip_sel), 64'd3);
    drive(32'h4000_0000, 2'b00, 1'b1);
    #1 check("selx_base", 64'(bus.selx), 64'b00001);
    drive(32'h3FFF_FFFF, 2'b00, 1'b1);
    #1 check("selx_below", 64'(bus.selx), 64'b10000);
    drive(32'hFFFF_FFFF, 2'b00, 1'b1);
    #1 check("selx_top", 64'(bus.selx), 64'b10000);
    tick();
    check("msel_def", 64'(bus.multip_sel), 64'd4);
    check_resp("idle_unmapped", 1'b1, 1'b0, 2'd0);

    // Unmapped NONSEQ -> two-cycle ERROR
    drive(32'h4000_4000, 2'b10, 1'b1);
    #1 check("selx_4000", 64'(bus.selx), 64'b10000);
    tick();
    check_resp("err1", 1'b0, 1'b1, 2'd1);
    check("eaddr_4000", 64'(bus.err_addr), 64'h4000_4000);
    drive(32'h4000_0000, 2'b00, 1'b0);
    tick();
    check_resp("err2", 1'b1, 1'b1, 2'd2);
    check("ecnt_err2", 64'(bus.err_count), 64'd0);
    drive(32'h4000_0000, 2'b00, 1'b1);
    tick();
    check_resp("err_done", 1'b1, 1'b0, 2'd0);
    check("ecnt_1", 64'(bus.err_count), 64'd1);

    // Wait states hold multip_sel
    drive(32'h4000_1000, 2'b10, 1'b1);
    tick();
    check("ws_msel1", 64'(bus.multip_sel), 64'd1);
    drive(32'h4000_2000, 2'b10, 1'b0);
    tick();
    check("ws_hold", 64'(bus.multip_sel), 64'd1);
    drive(32'h4000_2000, 2'b10, 1'b1);
    tick();
    check("ws_msel2", 64'(bus.multip_sel), 64'd2);

    // Back-to-back errors
    drive(32'h0000_0000, 2'b10, 1'b1);
    tick();
    check_resp("b2b_err1a", 1'b0, 1'b1, 2'd1);
    check("b2b_eaddr0", 64'(bus.err_addr), 64'h0);
    drive(32'h0000_0010, 2'b11, 1'b0);
    tick();
    check_resp("b2b_err2a", 1'b1, 1'b1, 2'd2);
    drive(32'h0000_0010, 2'b11, 1'b1);
    tick();
    check_resp("b2b_err1b", 1'b0, 1'b1, 2'd1);
    check("b2b_eaddr10", 64'(bus.err_addr), 64'h10);
    check("b2b_ecnt2", 64'(bus.err_count), 64'd2);
    drive(32'h0000_0000, 2'b00, 1'b0);
    tick();
    check_resp("b2b_err2b", 1'b1, 1'b1, 2'd2);
    drive(32'h0000_0000, 2'b00, 1'b1);
    tick();
    check_resp("b2b_idle", 1'b1, 1'b0, 2'd0);
    check("b2b_ecnt3", 64'(bus.err_count), 64'd3);

    // IDLE and BUSY to unmapped space: zero-wait OKAY, no count
    drive(32'h0000_0000, 2'b00, 1'b1);
    tick();
    check_resp("idle_tr", 1'b1, 1'b0, 2'd0);
    drive(32'h0000_0000, 2'b01, 1'b1);
    tick();
    check_resp("busy_tr", 1'b1, 1'b0, 2'd0);
    check("busy_ecnt", 64'(bus.err_count), 64'd3);
    check("busy_eaddr", 64'(bus.err_addr), 64'h10);

    // Saturation: 252 more errors reach 255, further errors hold it
    for (int i = 0; i < 257; i++) begin
      drive(32'h1000_0000, 2'b10, 1'b1);
      tick();
      drive(32'h1000_0000, 2'b00, 1'b0);
      tick();
      drive(32'h1000_0000, 2'b00, 1'b1);
      tick();
      if (i == 250) check("sat_254", 64'(bus.err_count), 64'd254);
      if (i == 251) check("sat_255", 64'(bus.err_count), 64'd255);
    end
    check("sat_hold", 64'(bus.err_count), 64'd255);

    // Reset in ERR1 abandons the error
    drive(32'h4000_5000, 2'b10, 1'b1);
    tick();
    check_resp("rst_mid_err1", 1'b0, 1'b1, 2'd1);
    check("rst_mid_eaddr", 64'(bus.err_addr), 64'h4000_5000);
    rst = 1'b1;
    drive(32'h4000_5000, 2'b00, 1'b0);
    tick();
    check_resp("rst_mid", 1'b1, 1'b0, 2'd0);
    check("rst_mid_msel", 64'(bus.multip_sel), 64'd4);
    check("rst_mid_ecnt", 64'(bus.err_count), 64'd0);
    check("rst_mid_eaddr0", 64'(bus.err_addr), 64'h0);
    rst = 1'b0;
    drive(32'h4000_0000, 2'b00, 1'b1);
    tick();
    check_resp("post_rst", 1'b1, 1'b0, 2'd0);
    check("post_rst_ecnt", 64'(bus.err_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_decoder.md
Name: ahb_decoder

Overview:
- Address-phase decoder for the AHB interconnect; sits between the master's address bus and the slave-side read-data multiplexor.
- Decodes the master address into a one-hot slave select, including a default-slave bit for unmapped space.
- Registers the data-phase select index that steers the multiplexor.
- Contains the default slave: a two-cycle ERROR responder for unmapped NONSEQ/SEQ transfers, with error-address capture and a saturating error counter.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- SLAVE_DEVICES, 4, number of mapped slaves (N).
- BASE_ADDR, 32'h4000_0000, start address of slave 0.
- REGION_SHIFT, 12, each slave region is 2^REGION_SHIFT bytes. Slave i covers [BASE_ADDR + (i<<REGION_SHIFT), BASE_ADDR + ((i+1)<<REGION_SHIFT) - 1].

Ports:
- clk, in, 1: bus clock.
- rst, in, 1: synchronous, active-high reset.
- addr, in, ADDR_WIDTH: master address (address phase).
- trans, in, 2: HTRANS; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- master_ready, in, 1: HREADY returned to master by the multiplexor.
- selx, out, N+1: one-hot select; bit N = default slave.
- multip_sel, out, clog2(N)+1: data-phase slave index to the multiplexor; value N = default slave.
- def_ready, out, 1: default-slave HREADYOUT.
- def_resp, out, 1: default-slave HRESP; 0 OKAY, 1 ERROR.
- err_addr, out, ADDR_WIDTH: address of the most recent erroring transfer.
- err_count, out, 8: saturating count of ERROR responses.

Behaviour:
- Reset values: multip_sel=N, def_ready=1, def_resp=0, err_addr=0, err_count=0, FSM=IDLE. selx is combinational and is not reset.
- selx, combinational and same cycle:
  - Compute off = addr - BASE_ADDR in ADDR_WIDTH+1 bits.
  - Hit if addr >= BASE_ADDR and off < (N<<REGION_SHIFT); then selx[off>>REGION_SHIFT]=1.
  - Otherwise selx[N]=1. Exactly one bit is always set.
  - selx does not depend on trans; slaves qualify with trans.
- multip_sel:
  - On clk edge with master_ready=1, loads the encoded index of selx.
  - Holds while master_ready=0.
  - Latency: one cycle after the accepted address phase, aligned to the data phase.
- Default-slave FSM, states IDLE / ERR1 / ERR2:
  - IDLE: def_ready=1, def_resp=0. If master_ready=1 and selx[N]=1 and trans[1]=1 (NONSEQ/SEQ), go to ERR1 and capture err_addr<=addr. IDLE/BUSY transfers to unmapped space get a zero-wait OKAY and the FSM stays in IDLE.
  - ERR1: def_ready=0, def_resp=1. Unconditionally go to ERR2.
  - ERR2: def_ready=1, def_resp=1. Increment err_count, saturating at 255.
    - If master_ready=1, selx[N]=1 and trans[1]=1, go to ERR1 and capture err_addr (back-to-back error).
    - Otherwise go to IDLE.
- FSM outputs are registered from the state, so there are no combinational paths from addr to def_ready/def_resp.
- Boundaries:
  - addr = BASE_ADDR + (N<<REGION_SHIFT) → default slave.
  - addr = BASE_ADDR - 1 → default slave.
  - Last byte of region N-1 → slave N-1.
  - The end of the region window must not wrap; the ADDR_WIDTH+1-bit compare guarantees this.
- rst takes priority in any state: the next cycle shows IDLE outputs and multip_sel=N. A transfer in flight is abandoned with no ERROR completion.

Test Plan:
Defaults used: BASE_ADDR=32'h4000_0000, REGION_SHIFT=12, N=4.
1. Reset: assert rst for 2 cycles → multip_sel=4, def_ready=1, def_resp=0, err_count=0, err_addr=0.
2. Mapped decode: NONSEQ addr=32'h4000_1004, master_ready=1 → selx=5'b00010 same cycle; multip_sel=1 after next edge. addr=32'h4000_3FFF → selx=5'b01000.
3. Unmapped error: NONSEQ addr=32'h4000_4000 → selx=5'b10000; then def_ready/def_resp = 0/1, then 1/1, then 1/0. err_addr=32'h4000_4000, err_count=1.
4. Wait states: multip_sel=1, master_ready=0, addr changes to 32'h4000_2000 → multip_sel stays 1. Raising master_ready → multip_sel=2 next cycle.
5. Back-to-back and IDLE: two consecutive NONSEQ to 32'h0000_0000 → ERR1, ERR2, ERR1, ERR2, IDLE; err_count +2. IDLE trans to 32'h0 → def_ready=1, def_resp=0, no count. 256 errors → err_count=255.
6. Reset mid-error: assert rst in ERR1 → next cycle def_ready=1, def_resp=0, multip_sel=4, err_count unchanged only if rst is low (with rst high it clears to 0).
